jtframe_i2s_tx: RTL
===================

// Module: jtframe_i2s_tx
// PURPOSE
//  Serialises the game's stereo sound (snd_left/snd_right after the frame's sound path) into an
//  I2S stream for the board DAC (BCLK/LRCLK/DATA pins). Sits downstream of the sound mixer, in the
//  target top level. Generates all I2S clocks from its own clock input; no DAC master clock.
// PARAMETERS
//  DW        16  sample width in bits
//  SLOTW     32  bit clocks per channel slot; SLOTW>=DW, else $error at elaboration
//  BCLK_DIV   8  clk cycles per bclk half period; >=1. 50MHz: bclk=3.125MHz, fs=48.83kHz
//  SIGNED     1  1: two's complement input; 0: unsigned input, MSB inverted before shifting
// PORTS
//  clk         in   1   system clock, rising edge
//  rst_n       in   1   asynchronous reset, active low
//  en          in   1   1: stream runs; 0: stop at end of current frame
//  l_data      in   DW  left sample, sampled only at frame start
//  r_data      in   DW  right sample, sampled only at frame start
//  sample_ack  out  1   one-clk pulse when l_data/r_data are captured
//  bclk        out  1   I2S bit clock
//  lrclk       out  1   word select; 0=left, 1=right
//  sdata       out  1   serial data, MSB first, changes on bclk falling edge
// BEHAVIOUR
//  - Reset: asynchronous; bclk=0, lrclk=0, sdata=0, sample_ack=0. Divider, period counter p and
//    shift registers cleared; state=IDLE. Reset mid-frame drops the frame; no partial output.
//  - Divider: cnt counts 0..BCLK_DIV-1; at cnt==BCLK_DIV-1, bclk toggles and cnt wraps to 0.
//    "fall" = the clk edge where bclk goes 1->0. All data, lrclk and p updates happen only on fall.
//  - States: IDLE and RUN.
//    IDLE: bclk is held 0 and cnt is held 0. When en=1, the next clk edge is treated as a fall
//    (frame start, see below) and the state goes to RUN.
//    RUN: the divider runs freely.
//  - Frame of 2*SLOTW bclk periods, p=0..2*SLOTW-1. p advances on each fall and wraps to 0.
//  - Frame start (fall into p=0):
//    - capture l_data and r_data into shift registers sl and sr;
//    - sample_ack=1 for exactly that clk; it is 0 on every other clk.
//  - sdata during p:
//    - p<SLOTW: left bit DW-1-p, or 0 when p>=DW;
//    - p>=SLOTW: right bit DW-1-(p-SLOTW), or 0 when p-SLOTW>=DW.
//  - lrclk leads data by one bclk (Philips I2S):
//    - lrclk=1 for p in SLOTW-1..2*SLOTW-2;
//    - lrclk=0 for p=2*SLOTW-1 and for p in 0..SLOTW-2.
//  - Latency: l_data/r_data presented before a frame start show their MSB on sdata at that fall
//    (0 clk latency after capture). The last captured pair repeats if the core does not update.
//  - en=0 while in RUN:
//    - the current frame completes through p=2*SLOTW-1;
//    - at the next fall the block enters IDLE instead of starting a new frame; p=0, lrclk=0,
//      sdata=0, no sample_ack.
//    - en toggled within a frame has no effect unless it is low at the frame-end fall.
//  - en=1 from IDLE: first frame starts on the clk after en is seen; sample_ack=1 on that clk.
//  - Arithmetic: p is $clog2(2*SLOTW) bits; cnt is $clog2(BCLK_DIV+1) bits. With SIGNED=0,
//    captured word = {~data[DW-1], data[DW-2:0]}. No rounding, no saturation.
// STRUCTURE
//  - No shared package: all constants are localparams derived from the parameters.
//  - One natural sub-module: jtframe_i2s_div (cnt, bclk, fall strobe, IDLE hold). Slot/shift logic
//    stays in jtframe_i2s_tx.
//  - Total RTL 150-250 lines.
// TESTING
//  1 Reset: hold rst_n=0 mid-frame -> bclk, lrclk, sdata, sample_ack read 0 on the same cycle;
//    release with en=0 -> outputs stay 0 for 1000 clk.
//  2 DW=16, SLOTW=32, BCLK_DIV=8, en=1, l=16'hA5C3, r=16'h8001 ->
//    - bclk period 16 clk;
//    - frame 1024 clk;
//    - left bits 1010010111000011 then 16 zeros, right bits 1000000000000001 then 16 zeros;
//    - lrclk rises 1 bclk before right MSB;
//    - sample_ack every 1024 clk.
//  3 SIGNED=0, l=16'h0000, r=16'hFFFF -> left serial word 16'h8000, right serial word 16'h7FFF.
//  4 Change l_data at p=5 -> current frame keeps the old left word; new value appears next frame;
//    exactly one sample_ack per frame.
//  5 Drop en at p=10 -> frame completes all 64 bclk, then bclk stays 0 with no sample_ack;
//    raise en -> sample_ack on the next clk and the MSB is valid at that fall.
//  6 BCLK_DIV=1, DW=24, SLOTW=24 -> bclk=clk/2, fs=clk/96, 24 data bits per slot, no zero padding;
//    scoreboard matches a reference I2S receiver model.

Source files
------------

// File: rtl/jtframe_i2s_div.sv
// Bit-clock divider for the I2S transmitter: free-running while run=1, parked low otherwise.
// fall marks the clk edge on which bclk goes from 1 to 0.
module jtframe_i2s_div #(
    parameter int BCLK_DIV = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic bclk,
    output logic fall
);
    localparam int CW = $clog2(BCLK_DIV + 1);

    logic [CW-1:0] cnt_r;
    logic          bclk_r;
    logic          wrap_s;

    assign wrap_s = (cnt_r == CW'(BCLK_DIV - 1));
    assign fall   = run & wrap_s & bclk_r;
    assign bclk   = bclk_r;

    // Half-period counter and bit clock; both held at zero while not running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            bclk_r <= 1'b0;
        end else if (!run) begin
            cnt_r  <= '0;
            bclk_r <= 1'b0;
        end else if (wrap_s) begin
            cnt_r  <= '0;
            bclk_r <= ~bclk_r;
        end else begin
            cnt_r  <= cnt_r + CW'(1);
            bclk_r <= bclk_r;
        end
    end
endmodule

// File: rtl/jtframe_i2s_tx.sv
// Philips I2S serialiser for the stereo sound path; derives bclk/lrclk from clk.
// Samples are captured once per frame, at the fall that starts slot 0.
module jtframe_i2s_tx #(
    parameter int DW       = 16,
    parameter int SLOTW    = 32,
    parameter int BCLK_DIV = 8,
    parameter int SIGNED   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [DW-1:0] l_data,
    input  logic [DW-1:0] r_data,
    output logic          sample_ack,
    output logic          bclk,
    output logic          lrclk,
    output logic          sdata
);
    localparam int FW = 2 * SLOTW;
    localparam int PW = $clog2(FW);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    if (SLOTW < DW) begin : g_bad_slotw
        $error("jtframe_i2s_tx: SLOTW must be >= DW");
    end
    if (BCLK_DIV < 1) begin : g_bad_div
        $error("jtframe_i2s_tx: BCLK_DIV must be >= 1");
    end

    // Unsigned input is re-centred by flipping the MSB
    function automatic logic [DW-1:0] to_word(input logic [DW-1:0] d);
        logic [DW-1:0] w;
        if (SIGNED != 0) begin
            w = d;
        end else begin
            w = {~d[DW-1], d[DW-2:0]};
        end
        return w;
    endfunction

    // Word select is high one bit ahead of the right slot, through its second-to-last bit
    function automatic logic lr_of(input logic [PW-1:0] p);
        return (p >= PW'(SLOTW - 1)) && (p <= PW'(FW - 2));
    endfunction

    state_t        state_r, state_nx_s;
    logic [PW-1:0] p_r, p_nx_s;
    logic [DW-1:0] sl_r, sr_r, l_word_s, r_word_s;
    logic          lrclk_r, sdata_r, ack_r;
    logic          div_fall_s, last_s, start_s, stop_s, step_s;

    jtframe_i2s_div #(.BCLK_DIV(BCLK_DIV)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (state_r == ST_RUN),
        .bclk  (bclk),
        .fall  (div_fall_s)
    );

    assign l_word_s = to_word(l_data);
    assign r_word_s = to_word(r_data);
    assign last_s   = (p_r == PW'(FW - 1));
    assign p_nx_s   = p_r + PW'(1);
    // Leaving IDLE counts as a fall, so the first frame starts on the very next edge
    assign start_s  = ((state_r == ST_IDLE) && en) || (div_fall_s && last_s && en);
    assign stop_s   = div_fall_s && last_s && !en;
    assign step_s   = div_fall_s && !last_s;

    assign sample_ack = ack_r;
    assign lrclk      = lrclk_r;
    assign sdata      = sdata_r;

    // Next-state decode for the IDLE/RUN controller
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (en) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Controller state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Slot counter, shift registers and serial outputs, all advanced on bclk falls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_r     <= '0;
            sl_r    <= '0;
            sr_r    <= '0;
            sdata_r <= 1'b0;
            lrclk_r <= 1'b0;
            ack_r   <= 1'b0;
        end else if (start_s) begin
            p_r     <= '0;
            sl_r    <= l_word_s << 1;
            sr_r    <= r_word_s;
            sdata_r <= l_word_s[DW-1];
            lrclk_r <= lr_of(PW'(0));
            ack_r   <= 1'b1;
        end else if (stop_s) begin
            p_r     <= '0;
            sdata_r <= 1'b0;
            lrclk_r <= 1'b0;
            ack_r   <= 1'b0;
        end else if (step_s) begin
            p_r     <= p_nx_s;
            lrclk_r <= lr_of(p_nx_s);
            ack_r   <= 1'b0;
            // Shifting out zeros pads the slot once the sample bits are used up
            if (p_nx_s < PW'(SLOTW)) begin
                sdata_r <= sl_r[DW-1];
                sl_r    <= sl_r << 1;
            end else begin
                sdata_r <= sr_r[DW-1];
                sr_r    <= sr_r << 1;
            end
        end else begin
            ack_r <= 1'b0;
        end
    end
endmodule
